prefetch_ar_arbiter: RTL and testbench

Shares one AXI read-address (AR) master port between the demand-miss path and NUM_PF prefetcher controllers.
- Demand has strict priority; prefetchers are served round-robin.
- Tracks outstanding prefetch reads per controller and blocks any controller at its limit.
- Sits between the prefetcher controllers' master ports and the memory-side AXI interconnect; snoops the R channel to retire requests.

---
 rtl/prefetch_ar_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_prefetch_ar_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_ar_arbiter.sv
// Shares one AXI AR master port between the demand-miss path and NUM_PF prefetchers.
// Define PF_STARVE_GUARD_EN to build the prefetcher starvation guard.
module prefetch_ar_arbiter #(
   parameter int unsigned NUM_PF       = 4,
   parameter int unsigned ADDR_BITS    = 64,
   parameter int unsigned ID_BITS      = 3,
   parameter int unsigned MAX_OUTSTAND = 8,
   parameter int unsigned CNT_BITS     = 4
) (
   input  logic                        clk,
   input  logic                        resetN,
   input  logic                        dmdValid,
   input  logic [ADDR_BITS-1:0]        dmdAddr,
   output logic                        dmdReady,
   input  logic [NUM_PF-1:0]           pfValid,
   input  logic [NUM_PF*ADDR_BITS-1:0] pfAddr,
   output logic [NUM_PF-1:0]           pfReady,
   output logic                        arValid,
   output logic [ADDR_BITS-1:0]        arAddr,
   output logic [ID_BITS-1:0]          arId,
   input  logic                        arReady,
   input  logic                        rDone,
   input  logic [ID_BITS-1:0]          rId,
   input  logic                        rLast,
   output logic [NUM_PF*CNT_BITS-1:0]  pfOutCnt,
   output logic                        errUnderflow
);

   localparam int unsigned         PtrBits = (NUM_PF > 1) ? $clog2(NUM_PF) : 1;
   localparam logic [ID_BITS-1:0]  DmdId   = ID_BITS'(NUM_PF);
   localparam logic [CNT_BITS-1:0] MaxCnt  = CNT_BITS'(MAX_OUTSTAND);
   localparam logic [CNT_BITS:0]   MaxOcc  = (CNT_BITS + 1)'(MAX_OUTSTAND);

   logic                 ar_valid_q, ar_valid_d;
   logic [ADDR_BITS-1:0] ar_addr_q, ar_addr_d;
   logic [ID_BITS-1:0]   ar_id_q, ar_id_d;
   logic [CNT_BITS-1:0]  cnt_q [NUM_PF];
   logic [CNT_BITS-1:0]  cnt_d [NUM_PF];
   logic [PtrBits-1:0]   rr_q, rr_d;
   logic                 err_q, err_d;

   logic                 slot_free;
   logic                 ar_hs;
   logic [ADDR_BITS-1:0] pf_addr [NUM_PF];
   logic [NUM_PF-1:0]    pf_pend;
   logic [NUM_PF-1:0]    pf_inc;
   logic [NUM_PF-1:0]    pf_dec;
   logic [NUM_PF-1:0]    pf_elig;
   logic                 pf_any;
   logic [PtrBits-1:0]   pf_sel;
   logic                 force_pf;
   logic                 grant_dmd;
   logic                 grant_pf;

   assign ar_hs     = ar_valid_q && arReady;
   assign slot_free = !ar_valid_q || arReady;

   for (genvar g = 0; g < NUM_PF; g++) begin : g_pf
      assign pf_addr[g] = pfAddr[g*ADDR_BITS +: ADDR_BITS];
      assign pf_pend[g] = ar_valid_q && (ar_id_q == ID_BITS'(g));
      assign pf_inc[g]  = ar_hs && (ar_id_q == ID_BITS'(g));
      assign pf_dec[g]  = rDone && rLast && (rId == ID_BITS'(g));
      // The request sitting in the AR slot is not yet counted but already committed,
      // so it is charged against the limit to keep the count from ever passing it.
      assign pf_elig[g] = pfValid[g] &&
                          (({1'b0, cnt_q[g]} + {{CNT_BITS{1'b0}}, pf_pend[g]}) < MaxOcc);
      assign pfOutCnt[g*CNT_BITS +: CNT_BITS] = cnt_q[g];
   end

   // Round-robin search: first eligible prefetcher at or after rr_q.
   always_comb begin
      int idx;
      pf_any = 1'b0;
      pf_sel = '0;
      idx    = 0;
      for (int i = 0; i < int'(NUM_PF); i++) begin
         idx = int'(rr_q) + i;
         if (idx >= int'(NUM_PF)) begin
            idx = idx - int'(NUM_PF);
         end
         if (!pf_any && pf_elig[idx[PtrBits-1:0]]) begin
            pf_any = 1'b1;
            pf_sel = idx[PtrBits-1:0];
         end
      end
   end

`ifdef PF_STARVE_GUARD_EN
   logic [2:0] starve_q, starve_d;

   assign force_pf = (starve_q == 3'd4) && pf_any;

   always_comb begin
      starve_d = starve_q;
      if (grant_pf) begin
         starve_d = '0;
      end else if (grant_dmd && pf_any) begin
         starve_d = starve_q + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   assign force_pf = 1'b0;
`endif

   assign grant_dmd = slot_free && dmdValid && !force_pf;
   assign grant_pf  = slot_free && !grant_dmd && pf_any;
   assign dmdReady  = grant_dmd;

   always_comb begin
      pfReady = '0;
      if (grant_pf) begin
         pfReady[pf_sel] = 1'b1;
      end
   end

   always_comb begin
      ar_valid_d = ar_valid_q;
      ar_addr_d  = ar_addr_q;
      ar_id_d    = ar_id_q;
      rr_d       = rr_q;
      if (grant_dmd) begin
         ar_valid_d = 1'b1;
         ar_addr_d  = dmdAddr;
         ar_id_d    = DmdId;
      end else if (grant_pf) begin
         ar_valid_d = 1'b1;
         ar_addr_d  = pf_addr[pf_sel];
         ar_id_d    = ID_BITS'(pf_sel);
         rr_d       = (pf_sel == PtrBits'(NUM_PF - 1)) ? '0 : pf_sel + 1'b1;
      end else if (ar_hs) begin
         ar_valid_d = 1'b0;
      end
   end

   // Issue and retire in the same cycle cancel; a retire at zero only flags the error.
   always_comb begin
      err_d = err_q;
      for (int k = 0; k < int'(NUM_PF); k++) begin
         cnt_d[k] = cnt_q[k];
         if (pf_inc[k] && !pf_dec[k]) begin
            if (cnt_q[k] != MaxCnt) begin
               cnt_d[k] = cnt_q[k] + 1'b1;
            end
         end else if (pf_dec[k] && !pf_inc[k]) begin
            if (cnt_q[k] == '0) begin
               err_d = 1'b1;
            end else begin
               cnt_d[k] = cnt_q[k] - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         ar_valid_q <= 1'b0;
         ar_addr_q  <= '0;
         ar_id_q    <= '0;
         rr_q       <= '0;
         err_q      <= 1'b0;
         for (int k = 0; k < int'(NUM_PF); k++) begin
            cnt_q[k] <= '0;
         end
      end else begin
         ar_valid_q <= ar_valid_d;
         ar_addr_q  <= ar_addr_d;
         ar_id_q    <= ar_id_d;
         rr_q       <= rr_d;
         err_q      <= err_d;
         for (int k = 0; k < int'(NUM_PF); k++) begin
            cnt_q[k] <= cnt_d[k];
         end
      end
   end

   assign arValid      = ar_valid_q;
   assign arAddr       = ar_addr_q;
   assign arId         = ar_id_q;
   assign errUnderflow = err_q;

   a_one_ready: assert property (@(posedge clk) disable iff (!resetN)
      $onehot0({dmdReady, pfReady}));

   a_stall_hold: assert property (@(posedge clk) disable iff (!resetN)
      (arValid && !arReady) |=> (arValid && $stable(arAddr) && $stable(arId)));

endmodule

// File: tb/tb_prefetch_ar_arbiter.sv
// Randomized and directed bench for prefetch_ar_arbiter against a behavioural model.
// Honours PF_STARVE_GUARD_EN the same way as the design.
module tb_prefetch_ar_arbiter;

   localparam int NUM_PF       = 4;
   localparam int ADDR_BITS    = 64;
   localparam int ID_BITS      = 3;
   localparam int MAX_OUTSTAND = 8;
   localparam int CNT_BITS     = 4;
`ifdef PF_STARVE_GUARD_EN
   localparam bit Starve = 1'b1;
`else
   localparam bit Starve = 1'b0;
`endif

   logic                        clk = 1'b0;
   logic                        resetN = 1'b0;
   logic                        dmdValid;
   logic [ADDR_BITS-1:0]        dmdAddr;
   logic                        dmdReady;
   logic [NUM_PF-1:0]           pfValid;
   logic [NUM_PF*ADDR_BITS-1:0] pfAddr;
   logic [NUM_PF-1:0]           pfReady;
   logic                        arValid;
   logic [ADDR_BITS-1:0]        arAddr;
   logic [ID_BITS-1:0]          arId;
   logic                        arReady;
   logic                        rDone;
   logic [ID_BITS-1:0]          rId;
   logic                        rLast;
   logic [NUM_PF*CNT_BITS-1:0]  pfOutCnt;
   logic                        errUnderflow;
   logic [ADDR_BITS-1:0]        pa [NUM_PF];

   always #5 clk = ~clk;

   always_comb begin
      pfAddr = '0;
      for (int k = 0; k < NUM_PF; k++) pfAddr[k*ADDR_BITS +: ADDR_BITS] = pa[k];
   end

   prefetch_ar_arbiter #(
      .NUM_PF(NUM_PF), .ADDR_BITS(ADDR_BITS), .ID_BITS(ID_BITS),
      .MAX_OUTSTAND(MAX_OUTSTAND), .CNT_BITS(CNT_BITS)
   ) dut (
      .clk(clk), .resetN(resetN),
      .dmdValid(dmdValid), .dmdAddr(dmdAddr), .dmdReady(dmdReady),
      .pfValid(pfValid), .pfAddr(pfAddr), .pfReady(pfReady),
      .arValid(arValid), .arAddr(arAddr), .arId(arId), .arReady(arReady),
      .rDone(rDone), .rId(rId), .rLast(rLast),
      .pfOutCnt(pfOutCnt), .errUnderflow(errUnderflow)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: what the AR slot holds, per-prefetcher outstanding reads, rotation point.
   bit          m_arv;
   logic [63:0] m_addr;
   int          m_id;
   int          m_cnt [NUM_PF];
   int          m_rr;
   bit          m_err;
   int          m_starve;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_arv = 0; m_addr = '0; m_id = 0; m_rr = 0; m_err = 0; m_starve = 0;
      for (int k = 0; k < NUM_PF; k++) m_cnt[k] = 0;
   endtask

   // Who gets the slot this cycle: -1 nobody, NUM_PF demand, else prefetcher index.
   task automatic model_grant(output int g, output bit any);
      bit elig [NUM_PF];
      int occ;
      any = 0;
      g   = -1;
      for (int k = 0; k < NUM_PF; k++) begin
         occ     = m_cnt[k] + ((m_arv && m_id == k) ? 1 : 0);
         elig[k] = pfValid[k] && (occ < MAX_OUTSTAND);
         if (elig[k]) any = 1;
      end
      if (m_arv && !arReady) return;
      if (dmdValid && !(Starve && m_starve == 4 && any)) begin
         g = NUM_PF;
         return;
      end
      for (int i = 0; i < NUM_PF; i++) begin
         if (elig[(m_rr + i) % NUM_PF]) begin
            g = (m_rr + i) % NUM_PF;
            return;
         end
      end
   endtask

   task automatic model_update(input int g, input bit any);
      bit hs, inc, dec;
      hs = m_arv && arReady;
      for (int k = 0; k < NUM_PF; k++) begin
         inc = hs && (m_id == k);
         dec = rDone && rLast && (int'(rId) == k);
         if (inc && !dec) begin
            if (m_cnt[k] < MAX_OUTSTAND) m_cnt[k]++;
         end else if (dec && !inc) begin
            if (m_cnt[k] == 0) m_err = 1;
            else m_cnt[k]--;
         end
      end
      if (g == NUM_PF) begin
         m_arv = 1; m_addr = dmdAddr; m_id = NUM_PF;
         if (any) m_starve++;
      end else if (g >= 0) begin
         m_arv = 1; m_addr = pa[g]; m_id = g;
         m_rr = (g + 1) % NUM_PF; m_starve = 0;
      end else if (hs) begin
         m_arv = 0;
      end
   endtask

   // One clock: check readies before the edge, registered outputs just after it.
   task automatic cycle(output logic dr, output logic [NUM_PF-1:0] pr);
      int g;
      bit any;
      logic [NUM_PF-1:0]          exp_pr;
      logic [NUM_PF*CNT_BITS-1:0] exp_cnt;
      #3;
      model_grant(g, any);
      dr = dmdReady;
      pr = pfReady;
      for (int k = 0; k < NUM_PF; k++) exp_pr[k] = (g == k);
      chk("dmdReady", 64'(dr), 64'(g == NUM_PF));
      chk("pfReady", 64'(pr), 64'(exp_pr));
      @(posedge clk);
      model_update(g, any);
      #1;
      for (int k = 0; k < NUM_PF; k++) exp_cnt[k*CNT_BITS +: CNT_BITS] = CNT_BITS'(m_cnt[k]);
      chk("arValid", 64'(arValid), 64'(m_arv));
      if (m_arv) begin
         chk("arAddr", arAddr, m_addr);
         chk("arId", 64'(arId), 64'(m_id));
      end
      chk("pfOutCnt", 64'(pfOutCnt), 64'(exp_cnt));
      chk("errUnderflow", 64'(errUnderflow), 64'(m_err));
   endtask

   task automatic clear_inputs();
      dmdValid = 0; dmdAddr = '0; pfValid = '0; arReady = 1;
      rDone = 0; rLast = 0; rId = '0;
      for (int k = 0; k < NUM_PF; k++) pa[k] = '0;
   endtask

   // Called just after a rising edge; the reset takes effect without waiting for a clock.
   task automatic do_reset();
      resetN = 0;
      #2;
      chk("rst arValid", 64'(arValid), 64'd0);
      chk("rst arAddr", arAddr, 64'd0);
      chk("rst arId", 64'(arId), 64'd0);
      chk("rst pfOutCnt", 64'(pfOutCnt), 64'd0);
      chk("rst errUnderflow", 64'(errUnderflow), 64'd0);
      @(posedge clk);
      #1;
      resetN = 1;
      model_reset();
   endtask

   initial begin
      logic              dr;
      logic [NUM_PF-1:0] pr;
      int                first;
      int                seq [5];
      seq = '{0, 1, 2, 3, 0};
      clear_inputs();
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // Single prefetch, one-cycle issue latency, count visible after the handshake.
      pfValid = 4'b0001; pa[0] = 64'h1000;
      cycle(dr, pr);
      chk("t1 pfReady", 64'(pr), 64'h1);
      chk("t1 arValid", 64'(arValid), 64'd1);
      chk("t1 arAddr", arAddr, 64'h1000);
      chk("t1 arId", 64'(arId), 64'd0);
      pfValid = '0;
      cycle(dr, pr);
      chk("t1 cnt0", 64'(pfOutCnt[3:0]), 64'd1);
      rDone = 1; rLast = 1; rId = 3'd0;
      cycle(dr, pr);
      rDone = 0; rLast = 0;

      // Demand beats a simultaneous prefetch.
      dmdValid = 1; dmdAddr = 64'h2000; pfValid = 4'b0010; pa[1] = 64'h3000;
      cycle(dr, pr);
      chk("t2 dmdReady", 64'(dr), 64'd1);
      chk("t2 arId", 64'(arId), 64'd4);
      chk("t2 arAddr", arAddr, 64'h2000);
      dmdValid = 0;
      cycle(dr, pr);
      chk("t2 pfReady", 64'(pr), 64'h2);
      chk("t2 arId pf1", 64'(arId), 64'd1);
      pfValid = '0;
      cycle(dr, pr);
      rDone = 1; rLast = 1; rId = 3'd4;
      cycle(dr, pr);
      rId = 3'd1;
      cycle(dr, pr);
      rDone = 0; rLast = 0;

      // Round-robin with no bubbles; reset here also lands mid-operation.
      pfValid = 4'b1111;
      do_reset();
      for (int k = 0; k < NUM_PF; k++) pa[k] = 64'h8000 + 64'(k) * 64'h40;
      for (int i = 0; i < 5; i++) begin
         cycle(dr, pr);
         chk("t3 arId seq", 64'(arId), 64'(seq[i]));
         chk("t3 arValid", 64'(arValid), 64'd1);
      end
      pfValid = '0;
      cycle(dr, pr);

      // Outstanding limit and release by a retire.
      do_reset();
      pfValid = 4'b0100; pa[2] = 64'h5000;
      for (int i = 0; i < 8; i++) begin
         cycle(dr, pr);
         chk("t4 pfReady2", 64'(pr), 64'h4);
      end
      cycle(dr, pr);
      chk("t4 blocked", 64'(pr), 64'h0);
      chk("t4 cnt2 full", 64'(pfOutCnt[11:8]), 64'd8);
      cycle(dr, pr);
      chk("t4 still blocked", 64'(pr), 64'h0);
      rDone = 1; rLast = 1; rId = 3'd2;
      cycle(dr, pr);
      chk("t4 retire cycle", 64'(pr), 64'h0);
      chk("t4 cnt2 after", 64'(pfOutCnt[11:8]), 64'd7);
      rDone = 0; rLast = 0;
      cycle(dr, pr);
      chk("t4 regrant", 64'(pr), 64'h4);
      pfValid = '0;
      cycle(dr, pr);

      // AR back-pressure holds the slot and every ready.
      do_reset();
      arReady = 0; pfValid = 4'b1000; pa[3] = 64'h4000;
      cycle(dr, pr);
      chk("t5 pf3 granted", 64'(pr), 64'h8);
      dmdValid = 1; dmdAddr = 64'h6000; pfValid = 4'b1001; pa[0] = 64'h7000;
      for (int i = 0; i < 5; i++) begin
         cycle(dr, pr);
         chk("t5 stall readies", 64'({dr, pr}), 64'd0);
         chk("t5 stall addr", arAddr, 64'h4000);
         chk("t5 stall id", 64'(arId), 64'd3);
      end
      arReady = 1;
      cycle(dr, pr);
      chk("t5 release dmdReady", 64'(dr), 64'd1);
      chk("t5 release arId", 64'(arId), 64'd4);
      dmdValid = 0; pfValid = '0;
      cycle(dr, pr);

      // Demand flood: the guard lets pf0 through after four demand grants.
      do_reset();
      dmdValid = 1; pfValid = 4'b0001; pa[0] = 64'h9000;
      first = 0;
      for (int i = 1; i <= 8; i++) begin
         dmdAddr = 64'hA000 + 64'(i);
         cycle(dr, pr);
         if (pr[0] && first == 0) first = i;
      end
      chk("t6 first pf0 grant", 64'(first), Starve ? 64'd5 : 64'd0);
      dmdValid = 0; pfValid = '0;
      cycle(dr, pr);
      cycle(dr, pr);

      // Underflow is sticky until reset.
      rDone = 1; rLast = 1; rId = 3'd1;
      cycle(dr, pr);
      rDone = 0; rLast = 0;
      chk("t7 err set", 64'(errUnderflow), 64'd1);
      for (int i = 0; i < 3; i++) cycle(dr, pr);
      chk("t7 err sticky", 64'(errUnderflow), 64'd1);
      do_reset();

      // Random traffic against the model.
      for (int n = 0; n < 4000; n++) begin
         dmdValid = ($urandom_range(0, 3) == 0);
         dmdAddr  = {$urandom, $urandom};
         pfValid  = NUM_PF'($urandom);
         for (int k = 0; k < NUM_PF; k++) pa[k] = {$urandom, $urandom};
         arReady  = ($urandom_range(0, 3) != 0);
         rDone    = ($urandom_range(0, 2) == 0);
         rLast    = ($urandom_range(0, 1) == 0);
         rId      = ID_BITS'($urandom_range(0, 7));
         if ($urandom_range(0, 999) == 0) do_reset();
         else cycle(dr, pr);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected end of test");
      $fatal(1, "timeout");
   end

endmodule
